uart_rx_alu_frontend: RTL and testbench
=======================================

UART_RX_ALU_FRONTEND -- requirements
Module: uart_rx_alu_frontend

Interface
- REQ-001 SHALL have parameter NB_DATA, default 8: width of the data byte, operands and result.
- REQ-002 SHALL have parameter NB_OP, default 6: width of the opcode.
- REQ-003 SHALL have parameter BAUD_DIV, default 326: i_clock cycles per oversampling tick (16 ticks per bit).
- REQ-004 SHALL use one clock; reset is synchronous and active-low.
- REQ-005 SHALL have port i_clock, input, 1 bit: system clock, all logic on the rising edge.
- REQ-006 SHALL have port i_reset, input, 1 bit: synchronous reset, asserted when 0.
- REQ-007 SHALL have port i_rx, input, 1 bit: UART serial line, idles at 1.
- REQ-008 SHALL have port i_alu_result, input, NB_DATA bits: result from the external ALU.
- REQ-009 SHALL have port o_dato_A, output, NB_DATA bits: latched operand A.
- REQ-010 SHALL have port o_dato_B, output, NB_DATA bits: latched operand B.
- REQ-011 SHALL have port o_OP, output, NB_OP bits: latched opcode.
- REQ-012 SHALL have port o_interface_data, output, NB_DATA bits: result byte for the transmitter.
- REQ-013 SHALL have port o_interface_done, output, 1 bit: one-cycle strobe marking o_interface_data valid.
- REQ-014 SHALL have port o_rx_data, output, NB_DATA bits: last received byte.
- REQ-015 SHALL have port o_rx_done, output, 1 bit: one-cycle strobe per received byte.

Function
- REQ-016 Tick generator SHALL count 0..BAUD_DIV-1 and wrap; internal tick is high for the one cycle the count equals BAUD_DIV-1 (every 326 clocks).
- REQ-017 Receiver SHALL implement an FSM with states IDLE, START, DATA and STOP, using a 4-bit tick counter and a 3-bit bit counter.
- REQ-018 In IDLE, i_rx=0 SHALL move the receiver to START and clear the tick counter.
- REQ-019 In START, on the 8th tick (mid-start), the receiver SHALL go to DATA if i_rx=0, otherwise back to IDLE as a glitch reject; counters cleared.
- REQ-020 In DATA, every 16th tick the receiver SHALL shift i_rx in LSB-first; after NB_DATA bits it SHALL go to STOP.
- REQ-021 In STOP, on the 16th tick (mid-stop) the receiver SHALL go to IDLE; if i_rx=1 it SHALL load o_rx_data and pulse o_rx_done for exactly 1 clock.
- REQ-022 If the stop bit samples 0 (framing error), the byte SHALL be discarded: no o_rx_done, o_rx_data unchanged.
- REQ-023 o_rx_data SHALL hold its value between frames.
- REQ-024 Interface SHALL implement an FSM with states WAIT_A, WAIT_B, WAIT_OP and SEND, advancing only on o_rx_done.
- REQ-025 In WAIT_A, o_rx_done SHALL latch o_dato_A ← o_rx_data and go to WAIT_B.
- REQ-026 In WAIT_B, o_rx_done SHALL latch o_dato_B ← o_rx_data and go to WAIT_OP.
- REQ-027 In WAIT_OP, o_rx_done SHALL latch o_OP ← o_rx_data[NB_OP-1:0] (upper bits ignored) and go to SEND.
- REQ-028 SEND SHALL last 1 clock: o_interface_data ← i_alu_result, o_interface_done=1 for that single cycle, then go to WAIT_A. Net latency is 2 clocks from the OP-byte o_rx_done to o_interface_done.
- REQ-029 Latched operands and opcode SHALL hold until overwritten by the next sequence; o_interface_data SHALL hold until the next SEND.
- REQ-030 i_alu_result SHALL be purely combinational from o_dato_A/o_dato_B/o_OP externally, so it is settled by SEND.

Reset
- REQ-031 With i_reset=0 at a clock edge: baud counter 0, receiver IDLE, interface WAIT_A.
- REQ-032 During reset all output registers SHALL be 0: o_rx_data, o_rx_done, o_dato_A, o_dato_B, o_OP, o_interface_data, o_interface_done.
- REQ-033 Reset mid-frame SHALL abort the frame with no strobe; reception restarts at the next falling edge after release.

Verification
- REQ-034 i_rx idle, no reset → tick every 326 clocks; no o_rx_done ever.
- REQ-035 Frame 0xAA at 16 ticks/bit (10432 ns at 2 ns clock) → o_rx_done pulse, o_rx_data=0xAA, o_dato_A=0xAA.
- REQ-036 Then frames 0x0F and 0x24 with i_alu_result=0xFF → o_dato_B=0x0F, o_OP=6'b100100; o_interface_done 1-cycle pulse 2 clocks after third o_rx_done; o_interface_data=0xFF.
- REQ-037 Low pulse of 4 ticks on i_rx → START rejects the glitch; no o_rx_done; FSM stays WAIT_A.
- REQ-038 Frame 0x55 with stop bit 0 → no o_rx_done, o_dato_A unchanged; the next valid frame is accepted.
- REQ-039 Assert reset during the 4th data bit of a frame → all outputs 0; a subsequent full frame 0x3C sets o_dato_A=0x3C.

Source files
------------

// File: rtl/uart_rx_alu_frontend.sv
// Purpose: UART receiver (16x oversampled, 8N1) feeding a 3-byte A/B/OP sequencer for an external ALU.
// Latency: o_rx_done at mid-stop bit; o_interface_done 2 clocks after the OP byte's o_rx_done.
// Backpressure: none; the serial line cannot be stalled, bytes are consumed as they arrive.
module uart_rx_alu_frontend #(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int BAUD_DIV = 326
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_dato_A,
    output logic [NB_DATA-1:0] o_dato_B,
    output logic [NB_OP-1:0]   o_OP,
    output logic [NB_DATA-1:0] o_interface_data,
    output logic               o_interface_done,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done
);

    localparam int NB_BAUD = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NB_BIT  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_BAUD-1:0] BAUD_LAST = NB_BAUD'(BAUD_DIV - 1);
    localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_DATA - 1);
    localparam logic [3:0]         TICK_MID  = 4'd7;
    localparam logic [3:0]         TICK_END  = 4'd15;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IF_WAIT_A, IF_WAIT_B, IF_WAIT_OP, IF_SEND} if_state_t;

    // ------------------------------------------------------------------
    // Oversampling tick generator
    // ------------------------------------------------------------------
    logic [NB_BAUD-1:0] r_baud_cnt;
    logic               w_tick;

    assign w_tick = (r_baud_cnt == BAUD_LAST);

    // Free-running divider, wraps on the tick cycle
    always_ff @(posedge i_clock) begin
        if (!i_reset)    r_baud_cnt <= '0;
        else if (w_tick) r_baud_cnt <= '0;
        else             r_baud_cnt <= r_baud_cnt + NB_BAUD'(1);
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t          r_rx_state;
    rx_state_t          w_rx_state_nxt;
    logic [3:0]         r_tick_cnt;
    logic [NB_BIT-1:0]  r_bit_cnt;
    logic [NB_DATA-1:0] r_shift;
    logic [NB_DATA-1:0] r_rx_data;
    logic               r_rx_done;
    logic               w_tick_clr;
    logic               w_tick_inc;
    logic               w_bit_clr;
    logic               w_bit_inc;
    logic               w_shift_en;
    logic               w_rx_load;

    // Receiver state register
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_rx_state <= RX_IDLE;
        else          r_rx_state <= w_rx_state_nxt;
    end

    // Receiver next-state: sample mid-start, every 16 ticks for data, mid-stop to finish
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        unique case (r_rx_state)
            RX_IDLE:  if (!i_rx) w_rx_state_nxt = RX_START;
            RX_START: if (w_tick && r_tick_cnt == TICK_MID)
                          w_rx_state_nxt = i_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && r_tick_cnt == TICK_END && r_bit_cnt == BIT_LAST)
                          w_rx_state_nxt = RX_STOP;
            RX_STOP:  if (w_tick && r_tick_cnt == TICK_END)
                          w_rx_state_nxt = RX_IDLE;
            default:  w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // Receiver datapath controls decoded from state, counters and line
    always_comb begin
        w_tick_clr = 1'b0;
        w_tick_inc = 1'b0;
        w_bit_clr  = 1'b0;
        w_bit_inc  = 1'b0;
        w_shift_en = 1'b0;
        w_rx_load  = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_tick_clr = !i_rx;
            end
            RX_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        w_tick_clr = 1'b1;
                        w_bit_clr  = 1'b1;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_END) begin
                        w_tick_clr = 1'b1;
                        w_shift_en = 1'b1;
                        w_bit_inc  = (r_bit_cnt != BIT_LAST);
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_END) begin
                        w_tick_clr = 1'b1;
                        // A low stop bit is a framing error: drop the byte silently
                        w_rx_load  = i_rx;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_tick_clr = 1'b1;
            end
        endcase
    end

    // Receiver counters, LSB-first shift register and registered byte/strobe
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            if (w_tick_clr)      r_tick_cnt <= '0;
            else if (w_tick_inc) r_tick_cnt <= r_tick_cnt + 4'd1;
            if (w_bit_clr)       r_bit_cnt <= '0;
            else if (w_bit_inc)  r_bit_cnt <= r_bit_cnt + NB_BIT'(1);
            if (w_shift_en)      r_shift <= {i_rx, r_shift[NB_DATA-1:1]};
            if (w_rx_load)       r_rx_data <= r_shift;
            r_rx_done <= w_rx_load;
        end
    end

    assign o_rx_data = r_rx_data;
    assign o_rx_done = r_rx_done;

    // ------------------------------------------------------------------
    // A / B / OP sequencer
    // ------------------------------------------------------------------
    if_state_t          r_if_state;
    if_state_t          w_if_state_nxt;
    logic [NB_DATA-1:0] r_dato_a;
    logic [NB_DATA-1:0] r_dato_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_if_data;
    logic               r_if_done;
    logic               w_ld_a;
    logic               w_ld_b;
    logic               w_ld_op;
    logic               w_send;

    // Sequencer state register
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_if_state <= IF_WAIT_A;
        else          r_if_state <= w_if_state_nxt;
    end

    // Sequencer next-state: advance on each accepted byte, SEND lasts one clock
    always_comb begin
        w_if_state_nxt = r_if_state;
        unique case (r_if_state)
            IF_WAIT_A:  if (r_rx_done) w_if_state_nxt = IF_WAIT_B;
            IF_WAIT_B:  if (r_rx_done) w_if_state_nxt = IF_WAIT_OP;
            IF_WAIT_OP: if (r_rx_done) w_if_state_nxt = IF_SEND;
            IF_SEND:    w_if_state_nxt = IF_WAIT_A;
            default:    w_if_state_nxt = IF_WAIT_A;
        endcase
    end

    // Sequencer load enables decoded from state
    always_comb begin
        w_ld_a  = (r_if_state == IF_WAIT_A)  && r_rx_done;
        w_ld_b  = (r_if_state == IF_WAIT_B)  && r_rx_done;
        w_ld_op = (r_if_state == IF_WAIT_OP) && r_rx_done;
        w_send  = (r_if_state == IF_SEND);
    end

    // Operand/opcode latches and result capture; ALU result is settled by SEND
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_dato_a  <= '0;
            r_dato_b  <= '0;
            r_op      <= '0;
            r_if_data <= '0;
            r_if_done <= 1'b0;
        end else begin
            if (w_ld_a)  r_dato_a  <= r_rx_data;
            if (w_ld_b)  r_dato_b  <= r_rx_data;
            if (w_ld_op) r_op      <= r_rx_data[NB_OP-1:0];
            if (w_send)  r_if_data <= i_alu_result;
            r_if_done <= w_send;
        end
    end

    assign o_dato_A         = r_dato_a;
    assign o_dato_B         = r_dato_b;
    assign o_OP             = r_op;
    assign o_interface_data = r_if_data;
    assign o_interface_done = r_if_done;

endmodule

// File: tb/tb_uart_rx_alu_frontend.sv
// Purpose: self-checking bench for uart_rx_alu_frontend (directed table, hand sequences, random frames).
// Latency: frames take 10 bit times of 16*TB_DIV clocks each.
// Backpressure: not applicable; stimulus is a free-running serial line.
module tb_uart_rx_alu_frontend;

    localparam int TB_DIV   = 4;
    localparam int BIT_CLKS = 16 * TB_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] alu_res;
    logic [7:0] dato_a, dato_b, if_data, rx_data;
    logic [5:0] op;
    logic       if_done, rx_done;
    bit         use_fixed = 1'b1;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int rx_cnt = 0, if_cnt = 0, dbl_cnt = 0;
    int last_rx_cyc = 0, last_if_cyc = 0;
    bit prev_rx = 1'b0, prev_if = 1'b0;

    // Behavioural expectation state
    logic [7:0] m_a, m_b, m_rx, m_if_data;
    logic [5:0] m_op;
    int         m_idx;

    always #1 clk = ~clk;

    uart_rx_alu_frontend #(.NB_DATA(8), .NB_OP(6), .BAUD_DIV(TB_DIV)) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_rx            (rx),
        .i_alu_result    (alu_res),
        .o_dato_A        (dato_a),
        .o_dato_B        (dato_b),
        .o_OP            (op),
        .o_interface_data(if_data),
        .o_interface_done(if_done),
        .o_rx_data       (rx_data),
        .o_rx_done       (rx_done)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o);
        case (o[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a | b);
            3'd6:    return a >> 1;
            default: return {a[6:0], b[7]};
        endcase
    endfunction

    assign alu_res = use_fixed ? 8'hFF : alu_fn(dato_a, dato_b, op);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            rx_cnt++;
            last_rx_cyc = cyc;
            if (prev_rx) dbl_cnt++;
        end
        if (if_done === 1'b1) begin
            if_cnt++;
            last_if_cyc = cyc;
            if (prev_if) dbl_cnt++;
        end
        prev_rx = (rx_done === 1'b1);
        prev_if = (if_done === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB-first, stop bit; a bad stop bit is a short low tail
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        rx = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT_CLKS);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_clk(BIT_CLKS);
        end else begin
            rx = 1'b0;
            wait_clk(40);
        end
        rx = 1'b1;
        wait_clk(64);
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] d, input bit stop_ok,
                                   input bit e_done, input logic [7:0] e_rx, input logic [7:0] e_a,
                                   input logic [7:0] e_b, input logic [5:0] e_op,
                                   input bit e_if, input logic [7:0] e_if_data);
        int r0, i0;
        r0 = rx_cnt;
        i0 = if_cnt;
        send_frame(d, stop_ok);
        chk({tag, ".rx_done_cnt"}, 32'(rx_cnt - r0), 32'(e_done));
        chk({tag, ".rx_data"}, 32'(rx_data), 32'(e_rx));
        chk({tag, ".dato_A"}, 32'(dato_a), 32'(e_a));
        chk({tag, ".dato_B"}, 32'(dato_b), 32'(e_b));
        chk({tag, ".OP"}, 32'(op), 32'(e_op));
        chk({tag, ".if_done_cnt"}, 32'(if_cnt - i0), 32'(e_if));
        chk({tag, ".if_data"}, 32'(if_data), 32'(e_if_data));
        if (e_if) chk({tag, ".latency"}, 32'(last_if_cyc - last_rx_cyc), 32'd2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, ".rx_done"}, 32'(rx_done), 32'd0);
        chk({tag, ".dato_A"}, 32'(dato_a), 32'd0);
        chk({tag, ".dato_B"}, 32'(dato_b), 32'd0);
        chk({tag, ".OP"}, 32'(op), 32'd0);
        chk({tag, ".if_data"}, 32'(if_data), 32'd0);
        chk({tag, ".if_done"}, 32'(if_done), 32'd0);
    endtask

    // Reference: every accepted byte fills A, then B, then OP; the OP byte yields one result
    task automatic model_byte(input logic [7:0] d, input bit stop_ok, output bit e_done, output bit e_if);
        e_done = stop_ok;
        e_if   = 1'b0;
        if (stop_ok) begin
            m_rx = d;
            if (m_idx == 0) m_a = d;
            else if (m_idx == 1) m_b = d;
            else begin
                m_op      = d[5:0];
                m_if_data = alu_fn(m_a, m_b, m_op);
                e_if      = 1'b1;
            end
            m_idx = (m_idx + 1) % 3;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         e_done;
        logic [7:0] e_rx;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic [5:0] e_op;
        bit         e_if;
        logic [7:0] e_if_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, t0;
        bit e_done, e_if;
        logic [7:0] d;
        bit ok;

        vecs[0] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 8'hAA, 8'h00, 6'h00, 1'b0, 8'h00};
        vecs[1] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 8'hAA, 8'h0F, 6'h00, 1'b0, 8'h00};
        vecs[2] = '{8'h24, 1'b1, 1'b1, 8'h24, 8'hAA, 8'h0F, 6'h24, 1'b1, 8'hFF};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 8'h24, 8'hAA, 8'h0F, 6'h24, 1'b0, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 8'h81, 8'h0F, 6'h24, 1'b0, 8'hFF};

        // Reset state
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clk(3);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Idle line: ticks every TB_DIV clocks, never a received byte
        t0 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut.w_tick) t0++;
        end
        chk("idle.tick_count", 32'(t0), 32'd50);
        chk("idle.rx_done_cnt", 32'(rx_cnt), 32'd0);
        chk("idle.if_done_cnt", 32'(if_cnt), 32'd0);

        // Directed table: A, B, OP with fixed ALU result
        for (int i = 0; i < 3; i++)
            frame_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, vecs[i].e_done,
                            vecs[i].e_rx, vecs[i].e_a, vecs[i].e_b, vecs[i].e_op,
                            vecs[i].e_if, vecs[i].e_if_data);

        // Short low glitch of 4 ticks must be rejected at mid-start
        r0 = rx_cnt;
        rx = 1'b0;
        wait_clk(4 * TB_DIV);
        rx = 1'b1;
        wait_clk(BIT_CLKS * 2);
        chk("glitch.rx_done_cnt", 32'(rx_cnt - r0), 32'd0);
        chk("glitch.dato_A", 32'(dato_a), 32'hAA);

        // Framing error then a valid byte landing in A
        for (int i = 3; i < 5; i++)
            frame_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, vecs[i].e_done,
                            vecs[i].e_rx, vecs[i].e_a, vecs[i].e_b, vecs[i].e_op,
                            vecs[i].e_if, vecs[i].e_if_data);

        // Reset in the middle of data bit 3 aborts the frame without a strobe
        r0 = rx_cnt;
        d  = 8'hC3;
        rx = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_clk(BIT_CLKS);
        end
        rx = d[3];
        wait_clk(BIT_CLKS / 2);
        rst_n = 1'b0;
        wait_clk(3);
        check_all_zero("midreset");
        rx    = 1'b1;
        rst_n = 1'b1;
        wait_clk(BIT_CLKS * 11);
        chk("midreset.rx_done_cnt", 32'(rx_cnt - r0), 32'd0);
        frame_and_check("after_reset", 8'h3C, 1'b1, 1'b1, 8'h3C, 8'h3C, 8'h00, 6'h00, 1'b0, 8'h00);

        // Randomized frames against the reference
        use_fixed = 1'b0;
        m_a = 8'h3C; m_b = 8'h00; m_op = 6'h00; m_rx = 8'h3C; m_if_data = 8'h00; m_idx = 1;
        for (int n = 0; n < 30; n++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            wait_clk($urandom_range(1, 100));
            model_byte(d, ok, e_done, e_if);
            frame_and_check($sformatf("rnd%0d", n), d, ok, e_done, m_rx, m_a, m_b, m_op, e_if, m_if_data);
        end

        chk("strobe_width", 32'(dbl_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
